// File: rtl/gcd_stein_engine.sv
// Purpose: multi-cycle binary (Stein) GCD coprocessor with go/done handshake, busy and all-zero flag.
// Latency: data-dependent, at most 2*WIDTH+3 clocks from the accepting edge to the edge that raises done.
// Backpressure: go is honoured only in IDLE; requests while busy are dropped, not queued.
// Optional: define GCD_CYCLE_COUNT_EN to add the cycles output (edges spent in SHIFT/ITER).
module gcd_stein_engine #(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH) + 1,
  parameter int CW    = $clog2(2*WIDTH + 4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             go,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy,
  output logic             zero_in
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [CW-1:0]    cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;

  logic             any_zero;
  logic             both_zero;
  logic             a_ge_b;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;
  logic [WIDTH-1:0] gcd_val;
  logic             finishing;

  // Reject parameter sets the datapath cannot represent (k range, cycle count range).
  if (WIDTH < 2 || KW < $clog2(WIDTH) + 1 || (1 << CW) < 2*WIDTH + 4) begin : g_bad_params
    $error("gcd_stein_engine: WIDTH/KW/CW out of range");
  end

  // Datapath helpers: one magnitude compare and two WIDTH-bit subtractors.
  assign any_zero  = (a == '0) || (b == '0);
  assign both_zero = (a == '0) && (b == '0);
  assign a_ge_b    = (a >= b);
  assign diff_ab   = a - b;
  assign diff_ba   = b - a;
  // One operand is zero here, so a|b is the surviving odd part; restore the common 2^k.
  assign gcd_val   = (a | b) << k;
  assign finishing = ((state == SHIFT) || (state == ITER)) && any_zero;

  assign busy = (state != IDLE);

  // Control FSM and result registers; rst discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      k       <= '0;
      out     <= '0;
      done    <= 1'b0;
      zero_in <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            a     <= in1;
            b     <= in2;
            k     <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (any_zero) begin
            out     <= gcd_val;
            zero_in <= both_zero;
            done    <= 1'b1;
            state   <= DONE;
          end else if (!a[0] && !b[0]) begin
            a <= a >> 1;
            b <= b >> 1;
            k <= k + KW'(1);
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          if (any_zero) begin
            out     <= gcd_val;
            zero_in <= both_zero;
            done    <= 1'b1;
            state   <= DONE;
          end else if (!a[0]) begin
            a <= a >> 1;
          end else if (!b[0]) begin
            b <= b >> 1;
          end else if (a_ge_b) begin
            a <= diff_ab >> 1;
          end else begin
            b <= diff_ba >> 1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [CW-1:0] cnt;

  // Count edges spent in SHIFT/ITER; the finishing edge is itself one of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      cycles <= '0;
    end else begin
      if (state == IDLE && go) begin
        cnt <= '0;
      end else if (state == SHIFT || state == ITER) begin
        cnt <= cnt + CW'(1);
      end
      if (finishing) begin
        cycles <= cnt + CW'(1);
      end
    end
  end
`else
  logic unused_finishing;
  assign unused_finishing = finishing;
`endif

endmodule

// File: tb/tb_gcd_stein_engine.sv
// Purpose: directed self-checking bench for gcd_stein_engine (WIDTH=32 and WIDTH=8 instances).
// Latency: results are awaited with bounded loops, never assumed fixed except where defined.
// Backpressure: exercises go while busy and go held across DONE.
module tb_gcd_stein_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        go  = 1'b0;
  logic [31:0] out;
  logic        done;
  logic        busy;
  logic        zero_in;
`ifdef GCD_CYCLE_COUNT_EN
  logic [6:0]  cycles;
`endif

  logic [7:0]  in1_8 = '0;
  logic [7:0]  in2_8 = '0;
  logic        go_8  = 1'b0;
  logic [7:0]  out_8;
  logic        done_8;
  logic        busy_8;
  logic        zero_in_8;
`ifdef GCD_CYCLE_COUNT_EN
  logic [4:0]  cycles_8;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gcd_stein_engine #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .go(go),
    .out(out), .done(done), .busy(busy), .zero_in(zero_in)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles)
`endif
  );

  gcd_stein_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in1(in1_8), .in2(in2_8), .go(go_8),
    .out(out_8), .done(done_8), .busy(busy_8), .zero_in(zero_in_8)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles_8)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with go for exactly one edge (the accepting edge when idle).
  task automatic start(input logic [31:0] x, input logic [31:0] y);
    in1 = x;
    in2 = y;
    go  = 1'b1;
    step();
    go  = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 80) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++;
    if (out !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || zero_in !== 1'b0) begin
      fails++;
      $display("FAIL reset: out=%0d done=%b busy=%b zero_in=%b, want 0/0/0/0", out, done, busy, zero_in);
    end
  endtask

  task automatic test_basic();
    int lat;
    int busy_cnt;
    start(32'd45, 32'd90);
    busy_cnt = 0;
    lat = 0;
    while (!done && lat < 80) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    tests++;
    if (lat !== 4 || done !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: done after %0d edges (done=%b), want 4", lat, done);
    end
    tests++;
    if (busy_cnt !== 4 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: busy cycles before done=%0d busy_at_done=%b, want 4/1", busy_cnt, busy);
    end
    tests++;
    if (out !== 32'd45 || zero_in !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: out=%0d zero_in=%b, want 45/0", out, zero_in);
    end
`ifdef GCD_CYCLE_COUNT_EN
    tests++;
    if (cycles !== 7'd4) begin
      fails++;
      $display("FAIL basic_cycles: cycles=%0d, want 4", cycles);
    end
`endif
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== 32'd45) begin
      fails++;
      $display("FAIL basic_after: done=%b busy=%b out=%0d, want 0/0/45", done, busy, out);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [3] = '{32'd48123, 32'd2000,  32'd35};
    logic [31:0] vb [3] = '{32'd628163, 32'd10000, 32'd49};
    logic [31:0] ve [3] = '{32'd1,     32'd2000,  32'd7};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start(va[i], vb[i]);
      wait_done(lat);
      tests++;
      if (done !== 1'b1 || lat > 67) begin
        fails++;
        $display("FAIL vec%0d_latency: done=%b after %0d edges, want done within 67", i, done, lat);
      end
      tests++;
      if (out !== ve[i] || zero_in !== 1'b0) begin
        fails++;
        $display("FAIL vec%0d_result: out=%0d zero_in=%b, want %0d/0", i, out, zero_in, ve[i]);
      end
      step();
      tests++;
      if (done !== 1'b0) begin
        fails++;
        $display("FAIL vec%0d_pulse: done=%b one cycle later, want 0", i, done);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] va [3] = '{32'd0,  32'd12, 32'd0};
    logic [31:0] vb [3] = '{32'd12, 32'd0,  32'd0};
    logic [31:0] ve [3] = '{32'd12, 32'd12, 32'd0};
    logic        vz [3] = '{1'b0,   1'b0,   1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start(va[i], vb[i]);
      wait_done(lat);
      tests++;
      if (done !== 1'b1 || lat > 2) begin
        fails++;
        $display("FAIL zero%0d_latency: done=%b after %0d edges, want within 2", i, done, lat);
      end
      tests++;
      if (out !== ve[i] || zero_in !== vz[i]) begin
        fails++;
        $display("FAIL zero%0d_result: out=%0d zero_in=%b, want %0d/%b", i, out, zero_in, ve[i], vz[i]);
      end
      step();
    end
  endtask

  task automatic test_pow2();
    int lat;
    start(32'd96, 32'd1024);
    wait_done(lat);
    tests++;
    if (done !== 1'b1 || out !== 32'd32) begin
      fails++;
      $display("FAIL pow2: done=%b out=%0d, want 1/32", done, out);
    end
    step();
  endtask

  task automatic test_width8();
    logic [7:0] va [2] = '{8'd128, 8'd255};
    logic [7:0] vb [2] = '{8'd64,  8'd255};
    logic [7:0] ve [2] = '{8'd64,  8'd255};
    int lat;
    for (int i = 0; i < 2; i++) begin
      in1_8 = va[i];
      in2_8 = vb[i];
      go_8  = 1'b1;
      step();
      go_8  = 1'b0;
      lat = 0;
      while (!done_8 && lat < 40) begin
        step();
        lat++;
      end
      tests++;
      if (done_8 !== 1'b1 || lat > 19 || out_8 !== ve[i]) begin
        fails++;
        $display("FAIL w8_%0d: done=%b lat=%0d out=%0d, want 1/<=19/%0d", i, done_8, lat, out_8, ve[i]);
      end
      step();
    end
  endtask

  task automatic test_go_busy();
    int ndone;
    int lat;
    logic [31:0] res;
    start(32'd2000, 32'd10000);
    for (int i = 0; i < 6; i++) step();
    in1 = 32'd35;
    in2 = 32'd49;
    go  = 1'b1;
    step();
    go  = 1'b0;
    ndone = 0;
    res   = '0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ndone++;
        res = out;
      end
      step();
    end
    tests++;
    if (ndone !== 1 || res !== 32'd2000) begin
      fails++;
      $display("FAIL go_busy: done pulses=%0d out=%0d, want 1/2000", ndone, res);
    end

    // go held high through DONE: the first idle edge starts a new operation.
    in1 = 32'd2000;
    in2 = 32'd10000;
    go  = 1'b1;
    step();
    in1 = 32'd35;
    in2 = 32'd49;
    wait_done(lat);
    tests++;
    if (done !== 1'b1 || out !== 32'd2000) begin
      fails++;
      $display("FAIL go_held_first: done=%b out=%0d, want 1/2000", done, out);
    end
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL go_held_idle: busy=%b after DONE, want 0", busy);
    end
    step();
    go = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL go_held_restart: busy=%b, want 1", busy);
    end
    wait_done(lat);
    tests++;
    if (done !== 1'b1 || out !== 32'd7) begin
      fails++;
      $display("FAIL go_held_second: done=%b out=%0d, want 1/7", done, out);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    start(32'd48123, 32'd628163);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0 || out !== 32'd0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: busy=%b out=%0d done=%b, want 0/0/0", busy, out, done);
    end
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      if (done) ndone++;
      step();
    end
    tests++;
    if (ndone !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_nodone: done pulses=%0d busy=%b, want 0/0", ndone, busy);
    end
    start(32'd45, 32'd90);
    wait_done(lat);
    tests++;
    if (done !== 1'b1 || out !== 32'd45) begin
      fails++;
      $display("FAIL reset_mid_restart: done=%b out=%0d, want 1/45", done, out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_zero();
    test_pow2();
    test_width8();
    test_go_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
